push_button_conditioner: RTL



---
 rtl/push_button_conditioner_pkg.sv | 22 ++
 rtl/push_button_conditioner_btn_channel.sv | 119 +++++++++++
 rtl/push_button_conditioner.sv | 36 +++
 3 files changed

// File: rtl/push_button_conditioner_pkg.sv
// push_button_conditioner_pkg: shared button indices, channel FSM encoding and default timing.
// Provides BTN_* bit positions on the push bus, the per-button FSM state type,
// default timing constants and a small max helper for counter sizing.
package push_button_conditioner_pkg;
   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;
   localparam int BTN_M = 4;
   localparam int DEF_N_BTN           = 5;
   localparam int DEF_DEBOUNCE_CYCLES = 20000;
   localparam int DEF_REPEAT_DELAY    = 500000;
   localparam int DEF_REPEAT_RATE     = 100000;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      REPEAT = 2'd2
   } btn_state_e;
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/push_button_conditioner_btn_channel.sv
// btn_channel: one button's synchroniser, debouncer, press one-shot and auto-repeat FSM.
// Ports: clk, reset (sync, active high); i_raw asynchronous pin; i_rep_en auto-repeat
// enable; o_level debounced level; o_pulse one-cycle press/repeat pulse; o_held high in
// the auto-repeat phase.
module btn_channel
   import push_button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   input  logic i_rep_en,
   output logic o_level,
   output logic o_pulse,
   output logic o_held
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic          r_ff1;
   logic          r_ff2;
   logic          r_stable;
   logic          r_pulse;
   logic [DW-1:0] r_deb_cnt;
   logic [RW-1:0] r_rep_cnt;
   btn_state_e    r_state;

   logic          w_differ;
   logic          w_flip;
   logic          w_rise;
   logic          w_fall;
   btn_state_e    w_state_nxt;
   logic [RW-1:0] w_rep_cnt_nxt;
   logic          w_pulse_nxt;

   // The debounced state flips on the same edge the FSM sees the rise/fall,
   // so the press pulse and the level change leave the block together.
   assign w_differ = r_ff2 ^ r_stable;
   assign w_flip   = w_differ && (r_deb_cnt == DEB_LAST);
   assign w_rise   = w_flip & r_ff2;
   assign w_fall   = w_flip & ~r_ff2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ff1     <= 1'b0;
         r_ff2     <= 1'b0;
         r_stable  <= 1'b0;
         r_deb_cnt <= '0;
         r_state   <= IDLE;
         r_rep_cnt <= '0;
         r_pulse   <= 1'b0;
      end else begin
         r_ff1     <= i_raw;
         r_ff2     <= r_ff1;
         r_stable  <= r_stable ^ w_flip;
         r_deb_cnt <= (w_differ && !w_flip) ? r_deb_cnt + 1'b1 : '0;
         r_state   <= w_state_nxt;
         r_rep_cnt <= w_rep_cnt_nxt;
         r_pulse   <= w_pulse_nxt;
      end
   end

   // Release is tested first in every pressed state so it beats a due pulse;
   // in PRESS the counter parks at the delay end until repeat is enabled.
   always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      w_pulse_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt   = PRESS;
               w_rep_cnt_nxt = '0;
               w_pulse_nxt   = 1'b1;
            end
         end
         PRESS: begin
            if (w_fall) begin
               w_state_nxt   = IDLE;
               w_rep_cnt_nxt = '0;
            end else if (i_rep_en && (r_rep_cnt == DLY_LAST)) begin
               w_state_nxt   = REPEAT;
               w_rep_cnt_nxt = '0;
               w_pulse_nxt   = 1'b1;
            end else if (r_rep_cnt != DLY_LAST) begin
               w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
         end
         REPEAT: begin
            if (w_fall) begin
               w_state_nxt   = IDLE;
               w_rep_cnt_nxt = '0;
            end else if (!i_rep_en) begin
               w_state_nxt   = PRESS;
               w_rep_cnt_nxt = '0;
            end else if (r_rep_cnt == RATE_LAST) begin
               w_rep_cnt_nxt = '0;
               w_pulse_nxt   = 1'b1;
            end else begin
               w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_rep_cnt_nxt = '0;
         end
      endcase
   end

   assign o_level = r_stable;
   assign o_pulse = r_pulse;
   assign o_held  = (r_state == REPEAT);
endmodule

// File: rtl/push_button_conditioner.sv
// push_button_conditioner: turns raw push-button pins into debounced levels and command pulses.
// Ports: clk, reset (sync, active high); push_raw asynchronous pins (0=up,1=down,2=left,
// 3=right,4=middle); repeat_en per-button auto-repeat enable; push_level debounced level;
// push_pulse one-cycle press/repeat pulses; push_held high during auto-repeat.
module push_button_conditioner
   import push_button_conditioner_pkg::*;
#(
   parameter int N_BTN           = DEF_N_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] push_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] push_level,
   output logic [N_BTN-1:0] push_pulse,
   output logic [N_BTN-1:0] push_held
);
   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .i_raw   (push_raw[g]),
         .i_rep_en(repeat_en[g]),
         .o_level (push_level[g]),
         .o_pulse (push_pulse[g]),
         .o_held  (push_held[g])
      );
   end
endmodule
